// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the HI/LO registers.
// Radix-2 iterative datapath: one product/quotient bit per clock.
// Ops are issued with start and tracked with busy/done; flush aborts.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PREP = 2'd1,
        S_RUN  = 2'd2,
        S_FIX  = 2'd3
    } state_t;

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    // FSM state
    state_t r_state;
    state_t w_next_state;

    // Latched operands and op attributes
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_is_div;
    logic             r_signed;

    // Iteration datapath
    logic [2*WIDTH-1:0] r_acc;    // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   r_opnd;   // multiplicand or divisor magnitude
    logic [CNT_W-1:0]   r_cnt;
    logic               r_q_neg;  // quotient / product sign
    logic               r_r_neg;  // remainder sign
    logic               r_dz;     // divisor was zero

    // Output registers
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;
    logic             r_div_zero;

    // Issue decode
    logic w_idle;
    logic w_accept_iter;
    logic w_accept_mthi;
    logic w_accept_mtlo;

    // PREP helpers
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic             w_b_zero;

    // RUN step results
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_acc;
    logic [WIDTH:0]     w_div_shift;
    logic               w_div_ok;
    logic [WIDTH-1:0]   w_div_rem;
    logic [2*WIDTH-1:0] w_div_acc;

    // FIX results
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_hi_res;
    logic [WIDTH-1:0]   w_lo_res;

    assign w_idle        = (r_state == S_IDLE);
    // Flush in IDLE suppresses any start presented in the same cycle.
    assign w_accept_iter = w_idle && start && !flush && !op[2];
    assign w_accept_mthi = w_idle && start && !flush && (op == OP_MTHI);
    assign w_accept_mtlo = w_idle && start && !flush && (op == OP_MTLO);

    assign w_a_mag  = (r_signed && r_a[WIDTH-1]) ? -r_a : r_a;
    assign w_b_mag  = (r_signed && r_b[WIDTH-1]) ? -r_b : r_b;
    assign w_b_zero = (r_b == '0);

    // Multiply step: conditionally add multiplicand into the upper half, then shift right.
    assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mul_acc = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide step: shift next dividend bit into the remainder, subtract if it fits.
    // The difference is always below the divisor, so its low WIDTH bits are exact.
    assign w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_ok    = (w_div_shift >= {1'b0, r_opnd});
    assign w_div_rem   = w_div_shift[WIDTH-1:0] - r_opnd;
    assign w_div_acc   = w_div_ok ? {w_div_rem, r_acc[WIDTH-2:0], 1'b1}
                                  : {w_div_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

    // Sign correction applied in FIX; divide-by-zero results carry clear sign flags.
    assign w_prod_fix = r_q_neg ? -r_acc : r_acc;
    assign w_hi_res   = r_is_div ? (r_r_neg ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH])
                                 : w_prod_fix[2*WIDTH-1:WIDTH];
    assign w_lo_res   = r_is_div ? (r_q_neg ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0])
                                 : w_prod_fix[WIDTH-1:0];

    // State register
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; flush overrides every transition
    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_accept_iter) w_next_state = S_PREP;
            S_PREP: w_next_state = (r_is_div && w_b_zero) ? S_FIX : S_RUN;
            S_RUN:  if (r_cnt == '0) w_next_state = S_FIX;
            S_FIX:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
        if (flush) begin
            w_next_state = S_IDLE;
        end
    end

    // Operand capture, PREP set-up and per-cycle iteration
    // NOTE: datapath flops are reset too, so an aborted op never leaves X-state behind.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a      <= '0;
            r_b      <= '0;
            r_is_div <= 1'b0;
            r_signed <= 1'b0;
            r_acc    <= '0;
            r_opnd   <= '0;
            r_cnt    <= '0;
            r_q_neg  <= 1'b0;
            r_r_neg  <= 1'b0;
            r_dz     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept_iter) begin
                        r_a      <= a;
                        r_b      <= b;
                        r_is_div <= op[1];
                        r_signed <= op[0];
                        r_dz     <= 1'b0;
                    end
                end
                S_PREP: begin
                    r_cnt   <= CNT_W'(WIDTH - 1);
                    r_q_neg <= r_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
                    r_r_neg <= r_signed & r_a[WIDTH-1];
                    if (r_is_div) begin
                        if (w_b_zero) begin
                            r_acc   <= {r_a, {WIDTH{1'b1}}};
                            r_q_neg <= 1'b0;
                            r_r_neg <= 1'b0;
                            r_dz    <= 1'b1;
                        end else begin
                            r_acc  <= {{WIDTH{1'b0}}, w_a_mag};
                            r_opnd <= w_b_mag;
                        end
                    end else begin
                        r_acc  <= {{WIDTH{1'b0}}, w_b_mag};
                        r_opnd <= w_a_mag;
                    end
                end
                S_RUN: begin
                    r_acc <= r_is_div ? w_div_acc : w_mul_acc;
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    // HI/LO write-back, done and div_zero pulses, and IDLE moves
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hi       <= '0;
            r_lo       <= '0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            if ((r_state == S_FIX) && !flush) begin
                r_hi       <= w_hi_res;
                r_lo       <= w_lo_res;
                r_done     <= 1'b1;
                r_div_zero <= r_dz;
            end else if (w_accept_mthi) begin
                r_hi <= a;
            end else if (w_accept_mtlo) begin
                r_lo <= a;
            end
        end
    end

    assign busy     = !w_idle;
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (WIDTH=32).
module tb_muldiv_unit;

    localparam int W = 32;

    localparam logic [2:0] OP_MULTU = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_DIVU  = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic         clk;
    logic         reset_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         flush;
    logic         busy;
    logic         done;
    logic         div_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int n_checks = 0;
    int n_errors = 0;

    muldiv_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .flush    (flush),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present an op and return #1 after its accepting edge (E0); operands are then scrambled.
    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 32'hA5A5_A5A5;
        b     = 32'h5A5A_5A5A;
    endtask

    // Count edges until done is seen (bounded); flag any non-busy cycle before it.
    task automatic wait_done(output int edges, output bit busy_ok);
        edges   = 0;
        busy_ok = 1'b1;
        if (!busy) busy_ok = 1'b0;
        while (!done && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
            if (!done && !busy) busy_ok = 1'b0;
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int lat, input logic [W-1:0] ehi,
                          input logic [W-1:0] elo, input logic edz);
        int n;
        bit bok;
        issue(o, x, y);
        wait_done(n, bok);
        check({tag, " latency"}, n, lat);
        check({tag, " busy held"}, bok, 1'b1);
        check({tag, " busy at done"}, busy, 1'b0);
        check({tag, " hi"}, hi, ehi);
        check({tag, " lo"}, lo, elo);
        check({tag, " div_zero"}, div_zero, edz);
        @(posedge clk);
        #1;
        check({tag, " done pulse width"}, done, 1'b0);
        check({tag, " div_zero pulse width"}, div_zero, 1'b0);
    endtask

    initial begin
        int n;
        int done_cnt;
        bit bok;

        reset_n = 1'b0;
        start   = 1'b0;
        op      = 3'b000;
        a       = '0;
        b       = '0;
        flush   = 1'b0;
        #3;
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset div_zero", div_zero, 0);
        #9 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Main arithmetic vectors
        run_op("multu max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult -3*5", OP_MULT, 32'hFFFF_FFFD, 32'h0000_0005, 34, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
        run_op("div -7/2", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 34, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("div ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 34, 32'h0000_0000, 32'h8000_0000, 1'b0);
        run_op("divu by 0", OP_DIVU, 32'h0000_002A, 32'h0000_0000, 2, 32'h0000_002A, 32'hFFFF_FFFF, 1'b1);

        // MTHI in IDLE: next-edge update, no done, LO untouched
        op    = OP_MTHI;
        a     = 32'h1234_5678;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("mthi hi", hi, 32'h1234_5678);
        check("mthi lo kept", lo, 32'hFFFF_FFFF);
        check("mthi no done", done, 0);
        check("mthi not busy", busy, 0);

        // DIVU with an MTLO presented at E5 (ignored while busy)
        issue(OP_DIVU, 32'h0000_0064, 32'h0000_0007);
        repeat (4) @(posedge clk);
        #1;
        op    = OP_MTLO;
        a     = 32'hDEAD_BEEF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(n, bok);
        check("divu+mtlo latency", n + 5, 34);
        check("divu+mtlo busy held", bok, 1'b1);
        check("divu+mtlo lo", lo, 32'h0000_000E);
        check("divu+mtlo hi", hi, 32'h0000_0002);
        @(posedge clk);
        #1;

        run_op("div 7/-2", OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 34, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);

        // Flush in IDLE blocks a same-cycle start
        op    = OP_MTHI;
        a     = 32'hCAFE_F00D;
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        check("idle flush hi kept", hi, 32'h0000_0001);
        check("idle flush busy", busy, 0);

        // Flush mid-MULTU: busy drops at E11, no done ever, HI/LO untouched
        issue(OP_MULTU, 32'h0000_0003, 32'h0000_0005);
        repeat (10) @(posedge clk);
        #1;
        check("flush busy at E10", busy, 1);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush busy at E11", busy, 0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        check("flush no done", done_cnt, 0);
        check("flush hi kept", hi, 32'h0000_0001);
        check("flush lo kept", lo, 32'hFFFF_FFFD);

        // Async reset mid-op: outputs clear without a clock edge
        issue(OP_MULTU, 32'h0000_0003, 32'h0000_0005);
        repeat (10) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("async rst hi", hi, 0);
        check("async rst lo", lo, 0);
        check("async rst busy", busy, 0);
        check("async rst done", done, 0);
        #2 reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back: next start presented while done is high
        issue(OP_MULTU, 32'h0000_0003, 32'h0000_0005);
        wait_done(n, bok);
        check("b2b first latency", n, 34);
        check("b2b first lo", lo, 32'h0000_000F);
        check("b2b first done", done, 1);
        issue(OP_MULTU, 32'h0000_0006, 32'h0000_0007);
        check("b2b second accepted", busy, 1);
        wait_done(n, bok);
        check("b2b second latency", n, 34);
        check("b2b second busy held", bok, 1'b1);
        check("b2b second hi", hi, 32'h0000_0000);
        check("b2b second lo", lo, 32'h0000_002A);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
